regfile_read_port: RTL and testbench

//   Read side of the CPU register file. Holds NUM_REGS x WIDTH storage built from enabled D flip-flops.

---
 rtl/regfile_read_port.sv | 113 +++++++++++
 tb/tb_regfile_read_port.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/regfile_read_port.sv
// Register-file read port: NUM_REGS x WIDTH flop storage (reg 0 tied to zero),
// one write port, and a two-operand read path. Each request is answered one
// cycle later from a single-entry response buffer with valid/ready on both sides.

// One storage register: enabled D flip-flop with async clear.
module regfile_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load on enable; clear on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

module regfile_read_port #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 32,
  parameter int AW       = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wrenable,
  input  logic [AW-1:0]    writeaddr,
  input  logic [WIDTH-1:0] writedata,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AW-1:0]    req_addr_a,
  input  logic [AW-1:0]    req_addr_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data_a,
  output logic [WIDTH-1:0] rsp_data_b
);

  typedef enum logic {EMPTY, FULL} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } rsp_t;

  logic [WIDTH-1:0] regs [NUM_REGS];
  logic [WIDTH-1:0] op_a, op_b;
  state_t           state, state_nxt;
  logic             accept;
  rsp_t             rsp_q;

  // Register 0 has no storage; it always reads zero.
  assign regs[0] = '0;

  // Storage array: one enabled cell per architectural register 1..NUM_REGS-1.
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    logic wr_en;
    assign wr_en = wrenable && (writeaddr == AW'(i));
    regfile_cell #(.WIDTH(WIDTH)) u_cell (
      .clk   (clk),
      .reset (reset),
      .en    (wr_en),
      .d     (writedata),
      .q     (regs[i])
    );
  end

  // Operand select: zero register wins, then same-cycle write bypass, then storage.
  always_comb begin
    op_a = regs[req_addr_a];
    if (wrenable && (writeaddr == req_addr_a)) op_a = writedata;
    if (req_addr_a == '0)                      op_a = '0;
    op_b = regs[req_addr_b];
    if (wrenable && (writeaddr == req_addr_b)) op_b = writedata;
    if (req_addr_b == '0)                      op_b = '0;
  end

  // Buffer occupancy register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  // Handshake and next-state: the buffer can take a new request when it is
  // empty or is being drained this cycle, so a full buffer streams 1/cycle.
  always_comb begin
    state_nxt = state;
    req_ready = (state == EMPTY) || rsp_ready;
    accept    = req_valid && req_ready;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (rsp_ready) state_nxt = accept ? FULL : EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Response buffer: snapshot operands on accept only, so a stalled response
  // is immune to later writes and data holds while the buffer is empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       rsp_q <= '0;
    else if (accept) rsp_q <= '{a: op_a, b: op_b};
  end

  assign rsp_valid  = (state == FULL);
  assign rsp_data_a = rsp_q.a;
  assign rsp_data_b = rsp_q.b;

endmodule

// File: tb/tb_regfile_read_port.sv
// Directed bench for regfile_read_port: reset, write/read, bypass, zero
// register, back-pressure snapshot, streaming and mid-stream reset.
module tb_regfile_read_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        wrenable;
  logic [4:0]  writeaddr;
  logic [31:0] writedata;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_addr_a;
  logic [4:0]  req_addr_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data_a;
  logic [31:0] rsp_data_b;

  int n_chk  = 0;
  int n_fail = 0;

  regfile_read_port #(.WIDTH(32), .NUM_REGS(32), .AW(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .wrenable   (wrenable),
    .writeaddr  (writeaddr),
    .writedata  (writedata),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr_a (req_addr_a),
    .req_addr_b (req_addr_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data_a (rsp_data_a),
    .rsp_data_b (rsp_data_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wrenable = 1'b1; writeaddr = a; writedata = d;
    tick();
    wrenable = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    req_valid = 1'b1; req_addr_a = a; req_addr_b = b;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wrenable = 1'b0; writeaddr = '0; writedata = '0;
    req_valid = 1'b0; req_addr_a = '0; req_addr_b = '0; rsp_ready = 1'b1;
    tick(); tick();
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_data_a", rsp_data_a, 32'd0);
    reset = 1'b0;
    tick();

    // 1. data present, then reset clears it
    wr(5'd3, 32'h0000_0033);
    rd(5'd3, 5'd3);
    chk("pre_reset_a", rsp_data_a, 32'h0000_0033);
    reset = 1'b1;
    #2;
    chk("async_reset_valid", 32'(rsp_valid), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    tick();
    reset = 1'b0;
    tick();
    req_valid = 1'b1; req_addr_a = 5'd3; req_addr_b = 5'd0;
    #1;
    chk("t1_req_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_a", rsp_data_a, 32'd0);
    chk("t1_b", rsp_data_b, 32'd0);
    chk("t1_req_ready_full", 32'(req_ready), 32'd1);
    tick();
    chk("t1_drained", 32'(rsp_valid), 32'd0);

    // 2. write then read
    wr(5'd5, 32'hDEAD_BEEF);
    rd(5'd5, 5'd5);
    chk("t2_a", rsp_data_a, 32'hDEAD_BEEF);
    chk("t2_b", rsp_data_b, 32'hDEAD_BEEF);
    tick();
    chk("t2_hold_data", rsp_data_a, 32'hDEAD_BEEF);

    // 3. same-cycle write bypass
    wr(5'd6, 32'h0000_0066);
    wrenable = 1'b1; writeaddr = 5'd7; writedata = 32'h1234_5678;
    rd(5'd7, 5'd6);
    wrenable = 1'b0;
    chk("t3_bypass_a", rsp_data_a, 32'h1234_5678);
    chk("t3_b", rsp_data_b, 32'h0000_0066);
    tick();

    // 4. writes to reg 0 are ignored and never bypassed
    wr(5'd0, 32'hFFFF_FFFF);
    wrenable = 1'b1; writeaddr = 5'd0; writedata = 32'hFFFF_FFFF;
    rd(5'd0, 5'd5);
    wrenable = 1'b0;
    chk("t4_zero_a", rsp_data_a, 32'd0);
    chk("t4_b", rsp_data_b, 32'hDEAD_BEEF);
    tick();

    // 5. back-pressure: held response is a snapshot
    wr(5'd9, 32'h0000_0009);
    rsp_ready = 1'b0;
    rd(5'd9, 5'd0);
    chk("t5_valid", 32'(rsp_valid), 32'd1);
    chk("t5_a", rsp_data_a, 32'h0000_0009);
    req_valid = 1'b1; req_addr_a = 5'd9; req_addr_b = 5'd0;
    wrenable = 1'b1; writeaddr = 5'd9; writedata = 32'h0000_000A;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t5_stall_ready%0d", i), 32'(req_ready), 32'd0);
      tick();
      wrenable = 1'b0;
      chk($sformatf("t5_stall_valid%0d", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("t5_stall_a%0d", i), rsp_data_a, 32'h0000_0009);
    end
    rsp_ready = 1'b1;
    #1;
    chk("t5_ready_on_drain", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk("t5_new_valid", 32'(rsp_valid), 32'd1);
    chk("t5_new_a", rsp_data_a, 32'h0000_000A);
    tick();
    chk("t5_no_dup", 32'(rsp_valid), 32'd0);

    // 6. streaming, then reset mid-stream
    for (int i = 0; i < 8; i++) wr(5'(10 + i), 32'h100 + 32'(i));
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_addr_a = 5'(10 + i); req_addr_b = 5'(17 - i);
      tick();
      chk($sformatf("t6_valid%0d", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("t6_a%0d", i), rsp_data_a, 32'h100 + 32'(i));
      chk($sformatf("t6_b%0d", i), rsp_data_b, 32'h100 + 32'(7 - i));
    end
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("t6_reset_valid", 32'(rsp_valid), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("t6_after_valid", 32'(rsp_valid), 32'd0);
    rd(5'd5, 5'd10);
    chk("t6_clr_a", rsp_data_a, 32'd0);
    chk("t6_clr_b", rsp_data_b, 32'd0);
    rd(5'd9, 5'd17);
    chk("t6_clr2_a", rsp_data_a, 32'd0);
    chk("t6_clr2_b", rsp_data_b, 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
